ram_responder: RTL and testbench
================================

RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 512, meaning number of 64-bit storage words (power of two).
REQ-002 SHALL have parameter WAIT_STATES, default 1, range 0..7, meaning extra HREADY-low cycles inserted per OKAY data phase.
REQ-003 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port HSEL, input, 1, slave select.
REQ-006 SHALL have port HTRANS, input, 1, transfer request (1 = active).
REQ-007 SHALL have port HADDR, input, 64, byte address.
REQ-008 SHALL have port HWRITE, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have port HSIZE, input, 3, access size: 0 byte, 1 half, 2 word, 3 dword; 4..7 illegal.
REQ-010 SHALL have port HWDATA, input, 64, write data, byte-lane aligned to HADDR[2:0].
REQ-011 SHALL have port HRDATA, output, 64, read data: full aligned dword containing the addressed bytes.
REQ-012 SHALL have port HREADY, output, 1, 1 = current data phase completes this cycle.
REQ-013 SHALL have port HRESP, output, 1, 0 = OKAY, 1 = ERROR.

Function
REQ-014 SHALL accept an address phase when HSEL & HTRANS & HREADY are all 1 at a rising edge, latching HADDR, HWRITE, HSIZE.
REQ-015 SHALL implement states IDLE, WAIT, DATA, ERR1, ERR2.
REQ-016 SHALL, on an accepted legal request, go to WAIT if WAIT_STATES>0 (holding a down-counter), else directly to DATA.
REQ-017 SHALL in WAIT drive HREADY=0, HRESP=0, decrement the counter, and enter DATA when it reaches 1.
REQ-018 SHALL in DATA drive HREADY=1, HRESP=0; a new address phase accepted in DATA SHALL chain directly (pipelined), else return to IDLE.
REQ-019 SHALL treat a request as illegal if HSIZE>3, the address is not size-aligned, or HADDR[63:3] >= DEPTH_WORDS.
REQ-020 SHALL answer an illegal request with ERR1 (HREADY=0, HRESP=1) then ERR2 (HREADY=1, HRESP=1), ignoring WAIT_STATES, with no storage change.
REQ-021 SHALL, for writes, sample HWDATA in the DATA cycle and commit only the byte lanes selected by HSIZE and HADDR[2:0] at the edge ending DATA.
REQ-022 SHALL, for reads, drive HRDATA in the DATA cycle from the storage word at the latched address, including any write committed at an earlier edge.
REQ-023 SHALL keep HRDATA at 0 in every cycle other than a read DATA cycle.
REQ-024 SHALL hold HREADY=1, HRESP=0 in IDLE; requests with HSEL=0 or HTRANS=0 SHALL be ignored.
REQ-025 SHALL, for back-to-back write then read of the same address with WAIT_STATES=0, return the newly written data.
REQ-026 SHALL ignore new requests while HREADY=0 (masters hold them until HREADY=1).

Reset
REQ-027 SHALL, while RESET=1, force state IDLE, counter 0, HREADY=1, HRESP=0, HRDATA=0, latched request cleared.
REQ-028 SHALL abort any in-flight transfer on RESET assertion; an uncommitted write SHALL NOT alter storage.
REQ-029 SHALL NOT initialise storage contents on reset.

Verification
REQ-030 Bench SHALL cover: WAIT_STATES=1, write dword 0x1122334455667788 to 0x10, then read 0x10 -> one HREADY-low cycle per phase, read HRDATA=0x1122334455667788, HRESP=0.
REQ-031 Bench SHALL cover: byte write 0xAB at 0x13 (HWDATA lane 3) over prior 0x1122334455667788 at 0x10 -> read 0x10 returns 0x11223344AB667788.
REQ-032 Bench SHALL cover: WAIT_STATES=0, write 0xDEAD to 0x20 then read 0x20 back-to-back -> HREADY stays 1, read HRDATA=0xDEAD.
REQ-033 Bench SHALL cover: word read at 0x06 (misaligned) and dword read at DEPTH_WORDS*8 -> each gives ERR1 (HREADY=0, HRESP=1) then ERR2 (HREADY=1, HRESP=1), storage unchanged.
REQ-034 Bench SHALL cover: RESET asserted during WAIT of a write to 0x30 (prior value 0x5) -> outputs reset immediately, later read of 0x30 returns 0x5.
REQ-035 Bench SHALL cover: HSEL=0 with HTRANS=1 for 4 cycles -> HREADY=1, HRESP=0, HRDATA=0 throughout.

Source files
------------

// File: rtl/ram_responder.sv
// Single-port 64-bit RAM behind a simple AHB-style slave: pipelined address/data
// phases, programmable wait states, and a two-cycle ERROR response for illegal requests.
module ram_responder #(
    parameter int DEPTH_WORDS = 512,
    parameter int WAIT_STATES = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        HSEL,
    input  logic        HTRANS,
    input  logic [63:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [63:0] HWDATA,
    output logic [63:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t        state;
    logic [2:0]    cnt;
    logic [AW-1:0] lat_word;
    logic [2:0]    lat_off;
    logic [1:0]    lat_size;
    logic          lat_write;
    logic [63:0]   mem [DEPTH_WORDS];

    logic       accept;
    logic       legal;
    logic [2:0] align_mask;
    logic [7:0] byte_en;

    assign accept = HSEL & HTRANS & HREADY;

    always_comb begin
        case (HSIZE)
            3'd0:    align_mask = 3'b000;
            3'd1:    align_mask = 3'b001;
            3'd2:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    end

    assign legal = (HSIZE <= 3'd3) && ((HADDR[2:0] & align_mask) == 3'b000)
                   && (HADDR[63:3] < 61'(DEPTH_WORDS));

    always_comb begin
        case (lat_size)
            2'd0:    byte_en = 8'h01;
            2'd1:    byte_en = 8'h03;
            2'd2:    byte_en = 8'h0F;
            default: byte_en = 8'hFF;
        endcase
        byte_en = byte_en << lat_off;
    end

    // HREADY/HRESP are registered alongside the state so they reflect the cycle being entered.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            cnt       <= 3'd0;
            HREADY    <= 1'b1;
            HRESP     <= 1'b0;
            lat_word  <= '0;
            lat_off   <= 3'd0;
            lat_size  <= 2'd0;
            lat_write <= 1'b0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (cnt == 3'd1) begin
                        state  <= S_DATA;
                        cnt    <= 3'd0;
                        HREADY <= 1'b1;
                        HRESP  <= 1'b0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                S_ERR1: begin
                    state  <= S_ERR2;
                    HREADY <= 1'b1;
                    HRESP  <= 1'b1;
                end
                default: begin
                    if (accept) begin
                        lat_word  <= HADDR[AW+2:3];
                        lat_off   <= HADDR[2:0];
                        lat_size  <= HSIZE[1:0];
                        lat_write <= HWRITE;
                        if (!legal) begin
                            state  <= S_ERR1;
                            HREADY <= 1'b0;
                            HRESP  <= 1'b1;
                        end else if (WAIT_STATES > 0) begin
                            state  <= S_WAIT;
                            cnt    <= 3'(WAIT_STATES);
                            HREADY <= 1'b0;
                            HRESP  <= 1'b0;
                        end else begin
                            state  <= S_DATA;
                            HREADY <= 1'b1;
                            HRESP  <= 1'b0;
                        end
                    end else begin
                        state  <= S_IDLE;
                        HREADY <= 1'b1;
                        HRESP  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Storage is deliberately not reset; a write lands only at the edge that ends its DATA cycle.
    always_ff @(posedge CLK) begin
        if (!RESET && state == S_DATA && lat_write) begin
            for (int b = 0; b < 8; b++) begin
                if (byte_en[b]) mem[lat_word][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    assign HRDATA = (state == S_DATA && !lat_write) ? mem[lat_word] : 64'd0;

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: one instance with one wait state, one with none,
// sharing the bus except for HSEL.
module tb_ram_responder;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        HTRANS, HWRITE;
    logic [63:0] HADDR, HWDATA;
    logic [2:0]  HSIZE;
    logic [1:0]  hsel;
    logic [63:0] rdata_a, rdata_b;
    logic        rdy_a, rdy_b, rsp_a, rsp_b;
    int          sel = 0;

    logic        rdy, rsp;
    logic [63:0] rdata;
    assign rdy   = (sel != 0) ? rdy_b   : rdy_a;
    assign rsp   = (sel != 0) ? rsp_b   : rsp_a;
    assign rdata = (sel != 0) ? rdata_b : rdata_a;

    ram_responder #(.DEPTH_WORDS(512), .WAIT_STATES(1)) u_ws1 (
        .CLK(CLK), .RESET(RESET), .HSEL(hsel[0]), .HTRANS(HTRANS), .HADDR(HADDR),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HRDATA(rdata_a), .HREADY(rdy_a), .HRESP(rsp_a)
    );

    ram_responder #(.DEPTH_WORDS(512), .WAIT_STATES(0)) u_ws0 (
        .CLK(CLK), .RESET(RESET), .HSEL(hsel[1]), .HTRANS(HTRANS), .HADDR(HADDR),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HRDATA(rdata_b), .HREADY(rdy_b), .HRESP(rsp_b)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       nm;
        logic        rd;
        logic [63:0] data;
        logic        err;
        int          lows;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic exp_t mk_exp(input string nm, input logic wr, input logic [63:0] rexp,
                                    input logic err);
        exp_t e;
        e.nm   = nm;
        e.rd   = !wr && !err;
        e.data = rexp;
        e.err  = err;
        e.lows = err ? 1 : ((sel == 0) ? 1 : 0);
        return e;
    endfunction

    // Entered at a negedge inside a data phase; consumes the low cycles and checks the completing one.
    task automatic collect();
        exp_t        e;
        int          n = 0;
        logic [63:0] want;
        if (sb.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL scoreboard_empty got 0 entries want >=1");
            return;
        end
        e = sb.pop_front();
        while (rdy !== 1'b1 && n < 20) begin
            vectors++;
            if (rsp !== e.err) begin
                miscompares++;
                $display("FAIL %s wait_hresp got %0b want %0b", e.nm, rsp, e.err);
            end
            vectors++;
            if (rdata !== 64'd0) begin
                miscompares++;
                $display("FAIL %s wait_hrdata got %h want 0", e.nm, rdata);
            end
            n++;
            @(negedge CLK);
        end
        vectors++;
        if (n != e.lows || rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s low_cycles got %0d (hready %b) want %0d", e.nm, n, rdy, e.lows);
        end
        vectors++;
        if (rsp !== e.err) begin
            miscompares++;
            $display("FAIL %s hresp got %0b want %0b", e.nm, rsp, e.err);
        end
        want = e.rd ? e.data : 64'd0;
        vectors++;
        if (rdata !== want) begin
            miscompares++;
            $display("FAIL %s hrdata got %h want %h", e.nm, rdata, want);
        end
    endtask

    task automatic xfer(input string nm, input logic wr, input logic [63:0] addr,
                        input logic [2:0] size, input logic [63:0] wd,
                        input logic [63:0] rexp, input logic err);
        @(negedge CLK);
        hsel = '0; hsel[sel] = 1'b1;
        HTRANS = 1'b1; HWRITE = wr; HADDR = addr; HSIZE = size;
        sb.push_back(mk_exp(nm, wr, rexp, err));
        @(posedge CLK);
        @(negedge CLK);
        hsel = '0; HTRANS = 1'b0; HWDATA = wd;
        collect();
    endtask

    task automatic check_idle_outputs(input string nm);
        vectors++;
        if (rdy_a !== 1'b1 || rdy_b !== 1'b1) begin
            miscompares++;
            $display("FAIL %s hready got %b/%b want 1/1", nm, rdy_a, rdy_b);
        end
        vectors++;
        if (rsp_a !== 1'b0 || rsp_b !== 1'b0) begin
            miscompares++;
            $display("FAIL %s hresp got %b/%b want 0/0", nm, rsp_a, rsp_b);
        end
        vectors++;
        if (rdata_a !== 64'd0 || rdata_b !== 64'd0) begin
            miscompares++;
            $display("FAIL %s hrdata got %h/%h want 0/0", nm, rdata_a, rdata_b);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; hsel = '0; HTRANS = 1'b0; HWRITE = 1'b0;
        HADDR = '0; HSIZE = 3'd0; HWDATA = '0;
        repeat (2) @(negedge CLK);
        check_idle_outputs("reset");
        RESET = 1'b0;
    endtask

    task automatic test_dword();
        sel = 0;
        xfer("dword_wr", 1'b1, 64'h10, 3'd3, 64'h1122334455667788, 64'd0, 1'b0);
        xfer("dword_rd", 1'b0, 64'h10, 3'd3, 64'd0, 64'h1122334455667788, 1'b0);
    endtask

    task automatic test_byte_lanes();
        sel = 0;
        xfer("byte_wr", 1'b1, 64'h13, 3'd0, 64'h00000000AB000000, 64'd0, 1'b0);
        xfer("byte_rd", 1'b0, 64'h10, 3'd3, 64'd0, 64'h11223344AB667788, 1'b0);
        xfer("half_wr", 1'b1, 64'h16, 3'd1, 64'hBEEF000000000000, 64'd0, 1'b0);
        xfer("half_rd", 1'b0, 64'h10, 3'd3, 64'd0, 64'hBEEF3344AB667788, 1'b0);
    endtask

    task automatic test_back_to_back();
        sel = 1;
        @(negedge CLK);
        hsel = 2'b10; HTRANS = 1'b1; HWRITE = 1'b1; HADDR = 64'h20; HSIZE = 3'd3;
        sb.push_back(mk_exp("b2b_wr", 1'b1, 64'd0, 1'b0));
        @(posedge CLK);
        @(negedge CLK);
        HWDATA = 64'hDEAD; HWRITE = 1'b0; HADDR = 64'h20; HSIZE = 3'd3;
        sb.push_back(mk_exp("b2b_rd", 1'b0, 64'hDEAD, 1'b0));
        collect();
        @(posedge CLK);
        @(negedge CLK);
        hsel = '0; HTRANS = 1'b0; HWDATA = 64'd0;
        collect();
    endtask

    task automatic test_errors();
        sel = 0;
        xfer("err_misalign", 1'b0, 64'h06, 3'd2, 64'd0, 64'd0, 1'b1);
        xfer("err_range", 1'b0, 64'h1000, 3'd3, 64'd0, 64'd0, 1'b1);
        xfer("err_range_wr", 1'b1, 64'h1010, 3'd3, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1);
        xfer("err_after_rd", 1'b0, 64'h10, 3'd3, 64'd0, 64'hBEEF3344AB667788, 1'b0);
        sel = 1;
        xfer("err_size_wr", 1'b1, 64'h20, 3'd4, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1);
        xfer("err_size_rd", 1'b0, 64'h20, 3'd3, 64'd0, 64'hDEAD, 1'b0);
    endtask

    task automatic test_reset_abort();
        sel = 0;
        xfer("abort_pre_wr", 1'b1, 64'h30, 3'd3, 64'h5, 64'd0, 1'b0);
        @(negedge CLK);
        hsel = 2'b01; HTRANS = 1'b1; HWRITE = 1'b1; HADDR = 64'h30; HSIZE = 3'd3;
        @(posedge CLK);
        @(negedge CLK);
        hsel = '0; HTRANS = 1'b0; HWDATA = 64'hFFFFFFFFFFFFFFFF;
        vectors++;
        if (rdy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_in_wait hready got %b want 0", rdy_a);
        end
        RESET = 1'b1;
        #1;
        check_idle_outputs("abort_reset");
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        xfer("abort_rd", 1'b0, 64'h30, 3'd3, 64'd0, 64'h5, 1'b0);
    endtask

    task automatic test_hsel_ignore();
        @(negedge CLK);
        hsel = '0; HTRANS = 1'b1; HWRITE = 1'b1; HADDR = 64'h10; HSIZE = 3'd3;
        HWDATA = 64'hFFFFFFFFFFFFFFFF;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            check_idle_outputs("hsel_off");
        end
        HTRANS = 1'b0;
        sel = 0;
        xfer("hsel_off_rd", 1'b0, 64'h10, 3'd3, 64'd0, 64'hBEEF3344AB667788, 1'b0);
    endtask

    initial begin
        test_reset();
        test_dword();
        test_byte_lanes();
        test_back_to_back();
        test_errors();
        test_reset_abort();
        test_hsel_ignore();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got running want finished");
        $fatal(1, "watchdog");
    end
endmodule
